// File: rtl/pet_pkg.sv
// Shared encodings for the pet mood engine: moods, need codes and the order in
// which needs are prioritised when several are critical at once.
package pet_pkg;

  typedef enum logic [2:0] {
    MOOD_OK    = 3'd0,
    MOOD_NEEDY = 3'd1,
    MOOD_SLEEP = 3'd2,
    MOOD_SICK  = 3'd3,
    MOOD_DEAD  = 3'd4
  } mood_e;

  typedef enum logic [2:0] {
    NEED_NONE      = 3'd0,
    NEED_HEALTH    = 3'd1,
    NEED_HUNGER    = 3'd2,
    NEED_HYGIENE   = 3'd3,
    NEED_ENERGY    = 3'd4,
    NEED_HAPPINESS = 3'd5,
    NEED_SOCIAL    = 3'd6
  } need_e;

  localparam int unsigned NUM_NEEDS      = 6;
  localparam int unsigned THRESH_DEFAULT = 12;

  // Critical-need vector bit i corresponds to need code i+1 (bit 0 = health, highest priority).
  localparam int unsigned  IDX_HEALTH  = 0;
  localparam int unsigned  IDX_ENERGY  = 3;
  localparam logic [5:0]   ENERGY_MASK = 6'b00_1000;

  function automatic need_e top_need(input logic [5:0] crit);
    need_e top;
    top = NEED_NONE;
    // Walk from lowest to highest priority so the highest critical need is assigned last.
    for (int unsigned i = 0; i < NUM_NEEDS; i++) begin
      if (crit[NUM_NEEDS-1-i]) top = need_e'(3'(NUM_NEEDS - i));
    end
    return top;
  endfunction

  function automatic logic [2:0] popcount6(input logic [5:0] v);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_NEEDS; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pet_mood_engine_tick_gen.sv
// Evaluation-tick prescaler: count wraps at TICK_DIV-1, tick is high for that one cycle.
module tick_gen #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int unsigned    CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              cnt_q <= '0;
    else if (cnt_q == LAST) cnt_q <= '0;
    else                    cnt_q <= cnt_q + 1'b1;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/pet_mood_engine.sv
// Pet mood engine: samples need stats each tick, runs the mood FSM, raises a
// prioritised care request with valid/ack handshake, and pulses an alert on bad-mood entry.
module pet_mood_engine
  import pet_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned THRESH     = THRESH_DEFAULT,
  parameter int unsigned SICK_TICKS = 8,
  parameter int unsigned DEAD_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hunger,
  input  logic [3:0] happiness,
  input  logic [3:0] health,
  input  logic [3:0] hygiene,
  input  logic [3:0] energy,
  input  logic [3:0] social,
  output logic [2:0] mood,
  output logic       need_valid,
  output logic [2:0] need_code,
  input  logic       need_ack,
  output logic       alert_pulse,
  output logic       dead
);

  localparam int unsigned SW = $clog2(SICK_TICKS + 1);
  localparam int unsigned DW = $clog2(DEAD_TICKS + 1);
  localparam logic [SW-1:0] SICK_MAX = SW'(SICK_TICKS);
  localparam logic [DW-1:0] DEAD_MAX = DW'(DEAD_TICKS);
  localparam logic [3:0]    TH       = 4'(THRESH);
  localparam logic [3:0]    WAKE     = 4'(THRESH / 2);

  logic          tick;
  logic [5:0]    crit;
  logic [2:0]    ncrit;
  logic          energy_only;
  need_e         top;

  mood_e         mood_q, mood_d;
  logic [SW-1:0] sick_q, sick_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          valid_q, alert_q;
  need_e         code_q, last_q;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  assign crit = {social >= TH, happiness >= TH, energy >= TH,
                 hygiene >= TH, hunger >= TH, health >= TH};
  assign ncrit       = popcount6(crit);
  assign energy_only = (crit == ENERGY_MASK);
  assign top         = top_need(crit);

  always_comb begin
    sick_d = sick_q;
    dcnt_d = dcnt_q;
    mood_d = mood_q;
    if (tick) begin
      if (ncrit >= 3'd2) sick_d = (sick_q == SICK_MAX) ? sick_q : sick_q + 1'b1;
      else               sick_d = '0;
      if (mood_q == MOOD_SICK && crit[IDX_HEALTH])
        dcnt_d = (dcnt_q == DEAD_MAX) ? dcnt_q : dcnt_q + 1'b1;
      else
        dcnt_d = '0;
      // Transitions compare against the post-update counters so SICK_TICKS
      // consecutive qualifying ticks are enough, including the current one.
      unique case (mood_q)
        MOOD_OK: begin
          if (energy_only)     mood_d = MOOD_SLEEP;
          else if (|crit)      mood_d = MOOD_NEEDY;
        end
        MOOD_NEEDY: begin
          if (ncrit == 3'd0)   mood_d = MOOD_OK;
          else if (energy_only) mood_d = MOOD_SLEEP;
          else if (sick_d == SICK_MAX) mood_d = MOOD_SICK;
        end
        MOOD_SLEEP: begin
          if (energy < WAKE)   mood_d = MOOD_OK;
          else if (|(crit & ~ENERGY_MASK)) mood_d = MOOD_NEEDY;
        end
        MOOD_SICK: begin
          if (!crit[IDX_HEALTH] && ncrit < 3'd2) mood_d = MOOD_NEEDY;
          else if (dcnt_d == DEAD_MAX)          mood_d = MOOD_DEAD;
        end
        default: mood_d = mood_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mood_q  <= MOOD_OK;
      sick_q  <= '0;
      dcnt_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= NEED_NONE;
      last_q  <= NEED_NONE;
      alert_q <= 1'b0;
    end else begin
      mood_q  <= mood_d;
      sick_q  <= sick_d;
      dcnt_q  <= dcnt_d;
      alert_q <= (mood_d != mood_q) &&
                 (mood_d inside {MOOD_NEEDY, MOOD_SICK, MOOD_DEAD});
      if (mood_d == MOOD_DEAD) begin
        valid_q <= 1'b0;
      end else if (valid_q && need_ack) begin
        // Ack takes precedence over a coincident tick; that tick's request evaluation is dropped.
        valid_q <= 1'b0;
        last_q  <= code_q;
      end else if (tick) begin
        if (top == NEED_NONE) last_q <= NEED_NONE;
        if (!valid_q && top != NEED_NONE && top != last_q) begin
          valid_q <= 1'b1;
          code_q  <= top;
        end
      end
    end
  end

  assign mood        = mood_q;
  assign need_valid  = valid_q;
  assign need_code   = code_q;
  assign alert_pulse = alert_q;
  assign dead        = (mood_q == MOOD_DEAD);

endmodule

// File: tb/tb_pet_mood_engine.sv
// Self-checking bench for pet_mood_engine: a tick-level reference model pushes
// expected outputs to a scoreboard queue that is popped after each evaluation tick.
module tb_pet_mood_engine;

  localparam int TDIV  = 4;
  localparam int SICKT = 2;
  localparam int DEADT = 3;
  localparam int TH    = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] st [6];   // priority order: health, hunger, hygiene, energy, happiness, social
  logic       need_ack;
  logic [2:0] mood, need_code;
  logic       need_valid, alert_pulse, dead;

  pet_mood_engine #(
    .TICK_DIV   (TDIV),
    .SICK_TICKS (SICKT),
    .DEAD_TICKS (DEADT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hunger      (st[1]),
    .happiness   (st[4]),
    .health      (st[0]),
    .hygiene     (st[2]),
    .energy      (st[3]),
    .social      (st[5]),
    .mood        (mood),
    .need_valid  (need_valid),
    .need_code   (need_code),
    .need_ack    (need_ack),
    .alert_pulse (alert_pulse),
    .dead        (dead)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] mood;
    logic       valid;
    logic [2:0] code;
    logic       alert;
    logic       dead;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ph;
  int   alert_seen = 0;

  // Reference model state
  int m_mood, m_sick, m_dcnt, m_code, m_last, m_alerts;
  bit m_valid;

  always @(posedge clk or posedge reset) begin
    if (reset) ph <= 0;
    else       ph <= (ph == TDIV - 1) ? 0 : ph + 1;
  end

  always @(negedge clk) if (alert_pulse === 1'b1) alert_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_mood = 0; m_sick = 0; m_dcnt = 0; m_code = 0; m_last = 0; m_valid = 0;
  endtask

  task automatic model_tick();
    logic [5:0] c;
    int n, t, nm;
    bit eo, al;
    exp_t e;
    c = '0; n = 0; t = 0; al = 0;
    for (int i = 0; i < 6; i++) begin
      if (st[i] >= TH) begin
        c[i] = 1'b1;
        n++;
        if (t == 0) t = i + 1;
      end
    end
    eo = (c == 6'b001000);
    if (m_mood != 4) begin
      m_sick = (n >= 2) ? ((m_sick < SICKT) ? m_sick + 1 : m_sick) : 0;
      m_dcnt = (m_mood == 3 && c[0]) ? ((m_dcnt < DEADT) ? m_dcnt + 1 : m_dcnt) : 0;
      nm = m_mood;
      case (m_mood)
        0: nm = eo ? 2 : (n > 0 ? 1 : 0);
        1: if (n == 0) nm = 0; else if (eo) nm = 2; else if (m_sick == SICKT) nm = 3;
        2: if (st[3] < TH / 2) nm = 0; else if ((c & 6'b110111) != 0) nm = 1;
        3: if (!c[0] && n < 2) nm = 1; else if (m_dcnt == DEADT) nm = 4;
        default: nm = m_mood;
      endcase
      al = (nm != m_mood) && (nm == 1 || nm == 3 || nm == 4);
      if (t == 0) m_last = 0;
      if (!m_valid && t != 0 && t != m_last) begin
        m_valid = 1;
        m_code  = t;
      end
      if (nm == 4) m_valid = 0;
      m_mood = nm;
    end
    if (al) m_alerts++;
    e.mood  = 3'(m_mood);
    e.valid = m_valid;
    e.code  = 3'(m_code);
    e.alert = al;
    e.dead  = (m_mood == 4);
    sb_q.push_back(e);
  endtask

  // Returns at the falling edge right after the next tick edge.
  task automatic wait_tick();
    do @(negedge clk); while (ph != 0);
  endtask

  task automatic do_tick(input string tag);
    exp_t e;
    model_tick();
    wait_tick();
    if (sb_q.size() == 0) begin
      check({tag, "/sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "/mood"},  32'(mood),        32'(e.mood));
      check({tag, "/valid"}, 32'(need_valid),  32'(e.valid));
      check({tag, "/code"},  32'(need_code),   32'(e.code));
      check({tag, "/alert"}, 32'(alert_pulse), 32'(e.alert));
      check({tag, "/dead"},  32'(dead),        32'(e.dead));
    end
  endtask

  task automatic do_ack(input string tag);
    need_ack = 1'b1;
    @(negedge clk);
    need_ack = 1'b0;
    if (m_valid) begin
      m_valid = 0;
      m_last  = m_code;
    end
    check({tag, "/ack_valid"}, 32'(need_valid), 32'(m_valid));
  endtask

  task automatic set_stats(input int h, input int hu, input int hy, input int en, input int ha, input int so);
    st[0] = 4'(h); st[1] = 4'(hu); st[2] = 4'(hy);
    st[3] = 4'(en); st[4] = 4'(ha); st[5] = 4'(so);
  endtask

  task automatic check_alerts(input string tag);
    #1;
    check({tag, "/alert_count"}, 32'(alert_seen), 32'(m_alerts));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    check({tag, "/rst_mood"},  32'(mood),        0);
    check({tag, "/rst_valid"}, 32'(need_valid),  0);
    check({tag, "/rst_code"},  32'(need_code),   0);
    check({tag, "/rst_alert"}, 32'(alert_pulse), 0);
    check({tag, "/rst_dead"},  32'(dead),        0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    need_ack = 1'b0;
    m_alerts = 0;
    set_stats(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset("init");

    // 1: idle pet stays OK
    for (int i = 0; i < 5; i++) do_tick("idle");
    check_alerts("idle");

    // 2: hunger request, held without ack, then acked with no re-request
    set_stats(0, 13, 0, 0, 0, 0);
    do_tick("hungry");
    for (int i = 0; i < 3; i++) do_tick("hold");
    do_ack("hungry");
    do_tick("no_rereq");
    do_tick("no_rereq2");
    check_alerts("hungry");

    // 3: sleep on energy-only, wake at low energy
    set_stats(0, 0, 0, 0, 0, 0);
    do_tick("calm");
    set_stats(0, 0, 0, 14, 0, 0);
    do_tick("sleep");
    set_stats(0, 0, 0, 5, 0, 0);
    do_tick("wake");
    do_ack("wake");
    check_alerts("sleep");

    // 4: sick then dead, terminal
    set_stats(15, 15, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) do_tick("decline");
    set_stats(0, 0, 0, 0, 0, 0);
    do_tick("dead_hold");
    do_tick("dead_hold2");
    check_alerts("dead");

    // 5: no merging, acked code suppressed until a different top need
    @(negedge clk);
    do_reset("r5");
    set_stats(0, 13, 0, 0, 0, 14);
    do_tick("two_needs");
    do_ack("two_needs");
    do_tick("suppr");
    do_tick("suppr2");
    set_stats(0, 0, 0, 0, 0, 14);
    do_tick("social");
    check_alerts("social");

    // 6: async reset while SICK with a pending request
    @(negedge clk);
    do_reset("r6");
    set_stats(15, 15, 0, 0, 0, 0);
    do_tick("pre_sick");
    do_tick("sick");
    do_reset("mid");
    do_tick("after_rst");
    check_alerts("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
